// File: rtl/hpm_counter_bank.sv
// Bank of NUM_CTRS performance counters with event selectors, inhibit mask and sticky overflow flags.
// Optional HPM_OVF_IRQ_EN adds per-counter irq enables and a registered overflow interrupt.
module hpm_counter_bank #(
  parameter int NUM_CTRS   = 4,
  parameter int CTR_WIDTH  = 64,
  parameter int NUM_EVENTS = 8,
  localparam int IDX_W = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1,
  localparam int SEL_W = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_we,
  input  logic [IDX_W-1:0]      csr_idx,
  input  logic [1:0]            csr_field,
  input  logic [31:0]           csr_wd,
  output logic [31:0]           csr_rd,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [NUM_CTRS-1:0]   ovf,
  output logic                  ovf_irq
);

  localparam logic [CTR_WIDTH-1:0] LO_MASK = CTR_WIDTH'(33'h0_FFFF_FFFF);
  localparam bit HAS_HI = (CTR_WIDTH > 32);

  logic [CTR_WIDTH-1:0] cnt     [NUM_CTRS];
  logic [CTR_WIDTH-1:0] cnt_nxt [NUM_CTRS];
  logic [SEL_W-1:0]     sel     [NUM_CTRS];
  logic [SEL_W-1:0]     sel_nxt [NUM_CTRS];
  logic [NUM_CTRS-1:0]  ovf_nxt;
  logic [NUM_CTRS-1:0]  inhibit;
  logic [NUM_CTRS-1:0]  hit;
  logic [NUM_EVENTS:0]  ev_pad;
  logic [CTR_WIDTH-1:0] wd_ext;
  logic                 idx_ok;

  // Selector value 0 maps onto the padded zero bit, so it never counts.
  assign ev_pad = {events, 1'b0};
  assign wd_ext = CTR_WIDTH'(csr_wd);
  assign idx_ok = (32'(csr_idx) < NUM_CTRS);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (!inhibit[i] && (32'(sel[i]) <= NUM_EVENTS)) hit[i] = ev_pad[sel[i]];
    end
  end

  always_comb begin
    ovf_nxt = ovf;
    for (int i = 0; i < NUM_CTRS; i++) begin
      cnt_nxt[i] = cnt[i];
      sel_nxt[i] = sel[i];
      if (csr_we && idx_ok && (32'(csr_idx) == i) && (csr_field == 2'd0)) begin
        cnt_nxt[i] = (cnt[i] & ~LO_MASK) | wd_ext;
      end else if (csr_we && idx_ok && (32'(csr_idx) == i) && (csr_field == 2'd1) && HAS_HI) begin
        cnt_nxt[i] = (cnt[i] & LO_MASK) | (wd_ext << 32);
      end else if (hit[i]) begin
        cnt_nxt[i] = cnt[i] + CTR_WIDTH'(1);
      end
      if (csr_we && idx_ok && (32'(csr_idx) == i) && (csr_field == 2'd2)) begin
        sel_nxt[i] = csr_wd[SEL_W-1:0];
        if (csr_wd[31]) ovf_nxt[i] = 1'b0;
      end
      // A wrap only counts when the increment actually happened; set beats W1C.
      if (hit[i] && (&cnt[i]) && (cnt_nxt[i] == '0)) ovf_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        cnt[i] <= '0;
        sel[i] <= '0;
      end
      ovf     <= '0;
      inhibit <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        cnt[i] <= cnt_nxt[i];
        sel[i] <= sel_nxt[i];
      end
      ovf <= ovf_nxt;
      if (csr_we && (csr_field == 2'd3)) inhibit <= csr_wd[NUM_CTRS-1:0];
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_CTRS-1:0] irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en  <= '0;
      ovf_irq <= 1'b0;
    end else begin
      ovf_irq <= |(ovf & irq_en);
      if (csr_we && (csr_field == 2'd3)) irq_en <= csr_wd[16 +: NUM_CTRS];
    end
  end
`else
  assign ovf_irq = 1'b0;
`endif

  always_comb begin
    csr_rd = '0;
    case (csr_field)
      2'd0: if (idx_ok) csr_rd = cnt[csr_idx][31:0];
      2'd1: if (idx_ok) csr_rd = 32'(cnt[csr_idx] >> 32);
      2'd2: if (idx_ok) begin
        csr_rd[SEL_W-1:0] = sel[csr_idx];
        csr_rd[31]        = ovf[csr_idx];
      end
      default: begin
        csr_rd[NUM_CTRS-1:0] = inhibit;
`ifdef HPM_OVF_IRQ_EN
        csr_rd[16 +: NUM_CTRS] = irq_en;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed and randomized checks of hpm_counter_bank against a behavioural model.
module tb_hpm_counter_bank;
  localparam int N  = 4;
  localparam int NE = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          csr_we;
  logic [1:0]    csr_idx;
  logic [1:0]    csr_field;
  logic [31:0]   csr_wd;
  logic [31:0]   csr_rd;
  logic [NE-1:0] events;
  logic [N-1:0]  ovf;
  logic          ovf_irq;

  int errors = 0;
  int checks = 0;

  longint unsigned m_cnt [N];
  int              m_sel [N];
  bit [N-1:0]      m_ovf = '0;
  bit [N-1:0]      m_inh = '0;
  bit [N-1:0]      m_en  = '0;
  bit              m_irq = 1'b0;

  always #5 clk = ~clk;

  hpm_counter_bank #(.NUM_CTRS(N), .CTR_WIDTH(64), .NUM_EVENTS(NE)) dut (
    .clk(clk), .reset(reset), .csr_we(csr_we), .csr_idx(csr_idx), .csr_field(csr_field),
    .csr_wd(csr_wd), .csr_rd(csr_rd), .events(events), .ovf(ovf), .ovf_irq(ovf_irq)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(int idx, int fld);
    logic [31:0] r;
    r = '0;
    if (fld == 3) begin
      r = 32'(m_inh);
`ifdef HPM_OVF_IRQ_EN
      r = r | (32'(m_en) << 16);
`endif
    end else if (idx < N) begin
      if (fld == 0) r = 32'(m_cnt[idx] % 64'h1_0000_0000);
      else if (fld == 1) r = 32'(m_cnt[idx] / 64'h1_0000_0000);
      else r = (m_ovf[idx] ? 32'h8000_0000 : 32'h0) + 32'(m_sel[idx]);
    end
    return r;
  endfunction

  // Reference model: state after each edge, from the inputs present at that edge.
  always @(posedge clk) begin
    bit hit [N];
    bit wrap;
    bit wr;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_sel[i] = 0;
      end
      m_ovf = '0; m_inh = '0; m_en = '0; m_irq = 1'b0;
    end else begin
`ifdef HPM_OVF_IRQ_EN
      m_irq = |(m_ovf & m_en);
`else
      m_irq = 1'b0;
`endif
      for (int i = 0; i < N; i++)
        hit[i] = !m_inh[i] && m_sel[i] >= 1 && m_sel[i] <= NE && events[m_sel[i]-1];
      for (int i = 0; i < N; i++) begin
        wr   = csr_we && (int'(csr_idx) == i);
        wrap = 1'b0;
        if (wr && csr_field == 2'd0)
          m_cnt[i] = (m_cnt[i] / 64'h1_0000_0000) * 64'h1_0000_0000 + longint'(csr_wd);
        else if (wr && csr_field == 2'd1)
          m_cnt[i] = (m_cnt[i] % 64'h1_0000_0000) + longint'(csr_wd) * 64'h1_0000_0000;
        else if (hit[i]) begin
          wrap = (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF);
          m_cnt[i] = m_cnt[i] + 1;
        end
        if (wr && csr_field == 2'd2) begin
          m_sel[i] = int'(csr_wd[3:0]);
          if (csr_wd[31]) m_ovf[i] = 1'b0;
        end
        if (wrap) m_ovf[i] = 1'b1;
      end
      if (csr_we && csr_field == 2'd3) begin
        m_inh = csr_wd[N-1:0];
`ifdef HPM_OVF_IRQ_EN
        m_en = csr_wd[16 +: N];
`endif
      end
    end
  end

  // Continuous comparison, away from the active edge.
  always @(negedge clk) begin
    check("cmp_csr_rd", 64'(csr_rd), 64'(exp_rd(int'(csr_idx), int'(csr_field))));
    check("cmp_ovf", 64'(ovf), 64'(m_ovf));
    check("cmp_ovf_irq", 64'(ovf_irq), 64'(m_irq));
  end

  task automatic drive(bit we, int idx, int fld, logic [31:0] wd, logic [NE-1:0] ev);
    csr_we = we; csr_idx = 2'(idx); csr_field = 2'(fld); csr_wd = wd; events = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(int idx, int fld, logic [31:0] exp, string name);
    csr_we = 1'b0; events = '0; csr_idx = 2'(idx); csr_field = 2'(fld);
    #1;
    check(name, 64'(csr_rd), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; csr_we = 1'b0; csr_idx = '0; csr_field = '0; csr_wd = '0; events = '0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    peek(0, 0, 32'h0, "rst_cnt_lo");
    peek(2, 2, 32'h0, "rst_sel");
    peek(0, 3, 32'h0, "rst_ctl");
    check("rst_ovf", 64'(ovf), 64'h0);
    check("rst_irq", 64'(ovf_irq), 64'h0);

    // Ten events on counter 0.
    drive(1, 0, 2, 32'h1, 0);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 8'h01);
    peek(0, 0, 32'd10, "count10");
    peek(1, 0, 32'd0, "ctr1_idle");
    peek(3, 0, 32'd0, "ctr3_idle");

    // Wrap from all-ones and W1C.
    drive(1, 0, 0, 32'hFFFF_FFFE, 0);
    drive(1, 0, 1, 32'hFFFF_FFFF, 0);
    drive(0, 0, 0, 0, 8'h01);
    peek(0, 0, 32'hFFFF_FFFF, "max_lo");
    peek(0, 1, 32'hFFFF_FFFF, "max_hi");
    check("no_ovf_yet", 64'(ovf[0]), 64'h0);
    drive(0, 0, 0, 0, 8'h01);
    peek(0, 0, 32'h0, "wrap_lo");
    peek(0, 1, 32'h0, "wrap_hi");
    check("wrap_ovf", 64'(ovf[0]), 64'h1);
    peek(0, 2, 32'h8000_0001, "wrap_status");
    drive(1, 0, 2, 32'h8000_0001, 0);
    peek(0, 2, 32'h0000_0001, "w1c_status");

    // Write wins over a concurrent event.
    drive(1, 0, 1, 32'hA, 0);
    drive(1, 0, 0, 32'h1234, 8'h01);
    peek(0, 0, 32'h1234, "write_wins_lo");
    peek(0, 1, 32'hA, "write_keeps_hi");

    // Inhibit counter 1 while events toggle.
    drive(1, 1, 2, 32'h1, 0);
    drive(1, 0, 3, 32'h2, 0);
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, (k % 2 == 0) ? 8'h01 : 8'h00);
    peek(0, 0, 32'h1237, "inh_ctr0_runs");
    peek(1, 0, 32'h0, "inh_ctr1_frozen");
    drive(1, 0, 3, 32'h0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 8'h01);
    peek(1, 0, 32'd4, "inh_ctr1_resumes");
    peek(0, 0, 32'h123B, "inh_ctr0_after");

    // Overflow interrupt path.
    drive(1, 0, 3, 32'h0001_0000, 0);
`ifdef HPM_OVF_IRQ_EN
    peek(0, 3, 32'h0001_0000, "irq_en_rd");
`else
    peek(0, 3, 32'h0, "irq_en_rd");
`endif
    drive(1, 0, 0, 32'hFFFF_FFFF, 0);
    drive(1, 0, 1, 32'hFFFF_FFFF, 0);
    drive(0, 0, 0, 0, 8'h01);
    check("irq_ovf_set", 64'(ovf[0]), 64'h1);
    check("irq_not_yet", 64'(ovf_irq), 64'h0);
    drive(0, 0, 0, 0, 0);
`ifdef HPM_OVF_IRQ_EN
    check("irq_asserted", 64'(ovf_irq), 64'h1);
`else
    check("irq_tied_low", 64'(ovf_irq), 64'h0);
`endif
    drive(1, 0, 2, 32'h8000_0001, 0);
    check("irq_ovf_cleared", 64'(ovf[0]), 64'h0);
    drive(0, 0, 0, 0, 0);
    check("irq_deasserted", 64'(ovf_irq), 64'h0);

    // Wrap and W1C on the same edge: flag stays set.
    drive(1, 0, 0, 32'hFFFF_FFFF, 0);
    drive(1, 0, 1, 32'hFFFF_FFFF, 0);
    drive(1, 0, 2, 32'h8000_0001, 8'h01);
    check("set_beats_w1c", 64'(ovf[0]), 64'h1);

    // Reset overrides a pending write and event.
    drive(0, 0, 0, 0, 8'h01);
    reset = 1'b1;
    drive(1, 0, 0, 32'h55, 8'h01);
    reset = 1'b0;
    peek(0, 0, 32'h0, "mrst_lo");
    peek(0, 1, 32'h0, "mrst_hi");
    peek(0, 2, 32'h0, "mrst_status");
    peek(1, 0, 32'h0, "mrst_ctr1");
    peek(0, 3, 32'h0, "mrst_ctl");
    check("mrst_ovf", 64'(ovf), 64'h0);

    // Randomized traffic; the negedge comparator checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] wd;
      case ($urandom_range(0, 3))
        0: wd = 32'hFFFF_FFFF;
        1: wd = 32'hFFFF_FFFE | ($urandom_range(0, 1) << 31);
        default: wd = $urandom;
      endcase
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, N-1), $urandom_range(0, 3), wd,
            NE'($urandom));
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
